// File: rtl/depth_test_unit.sv
// Depth test stage behind the rasterizer: strict less-than z-test against an external read-first z-buffer,
// writes survivors to z-buffer and framebuffer, and runs the per-frame clear of both buffers.
//
// state | meaning
// IDLE  | accepting fragments; i_clear starts a frame clear
// DRAIN | no new fragments; wait for the in-flight fragment in S1 to reach its write stage
// CLEAR | write '1 / CLEAR_COLOR to every address, one per cycle
module depth_test_unit #(
  parameter int DATAWIDTH     = 12,
  parameter int COLORWIDTH    = 4,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 320,
  parameter int ADDRWIDTH     = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
  parameter logic [COLORWIDTH-1:0] CLEAR_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  output logic                  o_ready,
  input  logic                  i_dv,
  input  logic [ADDRWIDTH-1:0]  i_addr,
  input  logic [DATAWIDTH-1:0]  i_depth,
  input  logic [COLORWIDTH-1:0] i_color,
  output logic                  o_zb_rd_en,
  output logic [ADDRWIDTH-1:0]  o_zb_rd_addr,
  input  logic [DATAWIDTH-1:0]  i_zb_rd_data,
  output logic                  o_zb_we,
  output logic [ADDRWIDTH-1:0]  o_zb_addr,
  output logic [DATAWIDTH-1:0]  o_zb_data,
  output logic                  o_fb_we,
  output logic [ADDRWIDTH-1:0]  o_fb_addr,
  output logic [COLORWIDTH-1:0] o_fb_data,
  output logic                  o_clear_done,
  output logic                  o_drop_err
);

  localparam int NPIX = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [ADDRWIDTH:0]   NPIX_EXT  = (ADDRWIDTH+1)'(NPIX);
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

  state_t                state, state_nxt;
  logic                  addr_ok, accept;
  logic                  s1_v;
  logic [ADDRWIDTH-1:0]  s1_addr;
  logic [DATAWIDTH-1:0]  s1_depth;
  logic [COLORWIDTH-1:0] s1_color;
  logic                  h_v;
  logic [ADDRWIDTH-1:0]  h_addr;
  logic [DATAWIDTH-1:0]  h_data;
  logic [DATAWIDTH-1:0]  stored;
  logic                  pass;
  logic [ADDRWIDTH-1:0]  clr_cnt, clr_addr_nxt;

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_clear) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (!s1_v) state_nxt = S_CLEAR;
      S_CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign addr_ok      = {1'b0, i_addr} < NPIX_EXT;
  assign accept       = i_dv & o_ready & addr_ok;
  assign o_zb_rd_en   = accept;
  assign o_zb_rd_addr = i_addr;
  assign clr_addr_nxt = (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;

  // The read was issued before the write in S2 commits, and the one in H committed on the read cycle itself.
  always_comb begin
    stored = i_zb_rd_data;
    if (o_zb_we && (o_zb_addr == s1_addr))
      stored = o_zb_data;
    else if (h_v && (h_addr == s1_addr))
      stored = h_data;
  end

  assign pass = s1_v && (s1_depth < stored);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      s1_v         <= 1'b0;
      s1_addr      <= '0;
      s1_depth     <= '0;
      s1_color     <= '0;
      h_v          <= 1'b0;
      h_addr       <= '0;
      h_data       <= '0;
      clr_cnt      <= '0;
      o_zb_we      <= 1'b0;
      o_zb_addr    <= '0;
      o_zb_data    <= '0;
      o_fb_we      <= 1'b0;
      o_fb_addr    <= '0;
      o_fb_data    <= '0;
      o_clear_done <= 1'b0;
      o_drop_err   <= 1'b0;
    end else begin
      state        <= state_nxt;
      s1_v         <= accept;
      s1_addr      <= i_addr;
      s1_depth     <= i_depth;
      s1_color     <= i_color;
      h_v          <= o_zb_we;
      h_addr       <= o_zb_addr;
      h_data       <= o_zb_data;
      o_clear_done <= 1'b0;
      // Clear writes are loaded on the edge entering each CLEAR cycle so they line up with the state.
      if (state_nxt == S_CLEAR) begin
        clr_cnt   <= clr_addr_nxt;
        o_zb_we   <= 1'b1;
        o_zb_addr <= clr_addr_nxt;
        o_zb_data <= '1;
        o_fb_we   <= 1'b1;
        o_fb_addr <= clr_addr_nxt;
        o_fb_data <= CLEAR_COLOR;
      end else begin
        o_zb_we   <= pass;
        o_zb_addr <= s1_addr;
        o_zb_data <= s1_depth;
        o_fb_we   <= pass;
        o_fb_addr <= s1_addr;
        o_fb_data <= s1_color;
      end
      if ((state == S_CLEAR) && (state_nxt == S_IDLE)) begin
        o_clear_done <= 1'b1;
        h_v          <= 1'b0;
      end
      if (i_dv && (!o_ready || !addr_ok)) o_drop_err <= 1'b1;
    end
  end

endmodule
